// File: rtl/cpu_state_dumper_if.sv
// Read-out bus for cpu_state_dumper: register-file and data-memory read ports
// plus the valid/ready word stream towards the monitor.
interface cpu_state_dumper_if #(parameter int IDX_W = 8);
  logic [4:0]       reg_addr;
  logic [31:0]      reg_data;
  logic             mem_rd_en;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [1:0]       out_tag;
  logic [IDX_W-1:0] out_index;
  logic             out_last;

  modport master (
    output reg_addr, input reg_data,
    output mem_rd_en, output mem_addr, input mem_data,
    output out_valid, input out_ready,
    output out_data, output out_tag, output out_index, output out_last
  );

  modport slave (
    input reg_addr, output reg_data,
    input mem_rd_en, input mem_addr, output mem_data,
    input out_valid, output out_ready,
    input out_data, input out_tag, input out_index, input out_last
  );
endinterface

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: after a run, streams every register, then every data
// memory word, out through a 2-entry staging FIFO.
// Optional feature macro: DUMP_CHECKSUM_EN adds a trailing XOR checksum word.
module cpu_state_dumper #(
  parameter int NUM_REGS   = 32,
  parameter int DMEM_WORDS = 64,
  parameter int IDX_W      = 8
) (
  input  logic               i_clock,
  input  logic               i_resetn,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  cpu_state_dumper_if.master bus
);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_REGS, S_MEM, S_CSUM, S_DRAIN} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_REGS, S_MEM, S_DRAIN} state_t;
`endif

  typedef struct packed {
    logic [31:0]      data;
    logic [1:0]       tag;
    logic [IDX_W-1:0] idx;
    logic             last;
  } word_t;

  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(DMEM_WORDS - 1);

  state_t           r_state, w_next;
  word_t            r_e0, r_e1, w_word;
  logic [1:0]       r_cnt;
  logic [IDX_W-1:0] r_ridx, r_midx, r_inf_addr;
  logic             r_inf, r_issued, r_done;

  logic       w_pop, w_room, w_reg_push, w_issue, w_cap, w_mem_last, w_push, w_final;
  logic [1:0] w_cnt_ap;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] r_csum;
  logic        w_cs_push;
`endif

  // Handshake bookkeeping: occupancy after this cycle's pop decides pushes/reads
  always_comb begin
    w_pop      = (r_cnt != 2'd0) & bus.out_ready;
    w_cnt_ap   = r_cnt - {1'b0, w_pop};
    w_room     = (w_cnt_ap != 2'd2);
    w_reg_push = (r_state == S_REGS) & w_room;
    // A read is only issued when its data is guaranteed a free slot next cycle
    w_issue    = (r_state == S_MEM) & ~r_issued & ((w_cnt_ap + {1'b0, r_inf}) <= 2'd1);
    w_cap      = r_inf;
    w_mem_last = w_cap & (r_inf_addr == LAST_MEM);
    w_final    = (r_state == S_DRAIN) & w_pop & (r_cnt == 2'd1);
`ifdef DUMP_CHECKSUM_EN
    w_cs_push  = (r_state == S_CSUM) & w_room;
    w_push     = w_reg_push | w_cap | w_cs_push;
`else
    w_push     = w_reg_push | w_cap;
`endif
  end

  // Word to push: captured memory data, current register, or checksum
  always_comb begin
    w_word = '0;
    if (w_cap) begin
`ifdef DUMP_CHECKSUM_EN
      w_word = '{data: bus.mem_data, tag: 2'b01, idx: r_inf_addr, last: 1'b0};
`else
      w_word = '{data: bus.mem_data, tag: 2'b01, idx: r_inf_addr,
                 last: (r_inf_addr == LAST_MEM)};
`endif
    end else if (w_reg_push) begin
      w_word = '{data: bus.reg_data, tag: 2'b00, idx: r_ridx, last: 1'b0};
    end
`ifdef DUMP_CHECKSUM_EN
    else if (w_cs_push) begin
      w_word = '{data: r_csum, tag: 2'b10, idx: '0, last: 1'b1};
    end
`endif
  end

  // State register
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_REGS;
      S_REGS:  if (w_reg_push && r_ridx == LAST_REG) w_next = S_MEM;
`ifdef DUMP_CHECKSUM_EN
      S_MEM:   if (w_mem_last) w_next = S_CSUM;
      S_CSUM:  if (w_cs_push) w_next = S_DRAIN;
`else
      S_MEM:   if (w_mem_last) w_next = S_DRAIN;
`endif
      S_DRAIN: if (w_final) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: stream fields come straight from the FIFO head
  always_comb begin
    o_busy        = (r_state != S_IDLE);
    o_done        = r_done;
    bus.reg_addr  = r_ridx[4:0];
    bus.mem_rd_en = w_issue;
    bus.mem_addr  = r_midx;
    bus.out_valid = (r_cnt != 2'd0);
    bus.out_data  = r_e0.data;
    bus.out_tag   = r_e0.tag;
    bus.out_index = r_e0.idx;
    bus.out_last  = r_e0.last;
  end

  // Counters, read tracking, checksum and the 2-entry FIFO
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_ridx     <= '0;
      r_midx     <= '0;
      r_inf_addr <= '0;
      r_inf      <= 1'b0;
      r_issued   <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= 2'd0;
      r_e0       <= '0;
      r_e1       <= '0;
`ifdef DUMP_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_done <= w_final;
      if (w_reg_push && r_ridx != LAST_REG) r_ridx <= r_ridx + 1'b1;
      r_inf <= w_issue;
      if (w_issue) begin
        r_inf_addr <= r_midx;
        if (r_midx == LAST_MEM) r_issued <= 1'b1;
        else                    r_midx   <= r_midx + 1'b1;
      end
`ifdef DUMP_CHECKSUM_EN
      if (w_push) r_csum <= r_csum ^ w_word.data;
`endif
      case ({w_push, w_pop})
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= w_word;
          else               r_e1 <= w_word;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) r_e0 <= w_word;
          else begin
            r_e0 <= r_e1;
            r_e1 <= w_word;
          end
        end
        default: ;
      endcase
      // Fresh dump: rewind both read counters
      if (r_state == S_IDLE && i_start) begin
        r_ridx   <= '0;
        r_midx   <= '0;
        r_issued <= 1'b0;
        r_inf    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
        r_csum   <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Directed bench for cpu_state_dumper: register/memory models, stream monitor,
// expected word sequence computed from the model contents.
module tb_cpu_state_dumper;
  localparam int NR = 32;
  localparam int ND = 64;
  localparam int IW = 8;
`ifdef DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NW = NR + ND + CS;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic busy, done;
  logic [31:0] rf [NR];
  logic [31:0] dmem [ND];
  logic [31:0] mem_q = '0;

  cpu_state_dumper_if #(.IDX_W(IW)) bus();

  cpu_state_dumper #(.NUM_REGS(NR), .DMEM_WORDS(ND), .IDX_W(IW)) dut (
    .i_clock(clk), .i_resetn(resetn), .i_start(start),
    .o_busy(busy), .o_done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.reg_data = rf[bus.reg_addr];
  assign bus.mem_data = mem_q;
  always @(posedge clk) if (bus.mem_rd_en) mem_q <= dmem[bus.mem_addr[5:0]];

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [42:0] cur_w();
    return {bus.out_data, bus.out_tag, bus.out_index, bus.out_last};
  endfunction

  function automatic logic [42:0] exp_word(input int k);
    logic [31:0] x;
    x = '0;
    if (k < NR) return {rf[k], 2'b00, 8'(k), 1'b0};
    if (k < NR + ND) return {dmem[k-NR], 2'b01, 8'(k-NR), (k == NR+ND-1) && (CS == 0)};
    for (int i = 0; i < NR; i++) x ^= rf[i];
    for (int i = 0; i < ND; i++) x ^= dmem[i];
    return {x, 2'b10, 8'd0, 1'b1};
  endfunction

  // Monitor: drives ready, records transfers, checks stall stability and Done
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_xfer = 0, rdy_mode = 0;
  logic stall_prev = 1'b0;
  logic [42:0] prev_w = '0;
  logic [42:0] q[$];

  always @(negedge clk) begin
    cyc++;
    bus.out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
    if (stall_prev && resetn)
      chk("stall_hold", {20'd0, bus.out_valid, cur_w()}, {20'd0, 1'b1, prev_w});
    if (bus.out_valid && bus.out_ready && resetn) begin
      q.push_back(cur_w());
      last_xfer = cyc;
    end
    stall_prev = bus.out_valid && !bus.out_ready && resetn;
    prev_w = cur_w();
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk_idle_outs(input string tag);
    chk(tag, {busy, done, bus.out_valid, bus.out_last, bus.out_data, bus.out_tag,
              bus.out_index, bus.mem_rd_en, bus.mem_addr, bus.reg_addr}, 64'd0);
  endtask

  task automatic start_dump(output int s);
    @(negedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && !done; i++) begin
      @(negedge clk); #1;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_words(input int n, input int lim);
    for (int i = 0; i < lim && q.size() < n; i++) begin
      @(negedge clk); #1;
    end
    if (q.size() < n) chk("words_timeout", q.size(), n);
  endtask

  task automatic check_seq(input int off, input int total);
    chk("nwords", q.size(), total);
    for (int k = 0; k < NW && off + k < q.size(); k++)
      chk($sformatf("word%0d", k), q[off+k], exp_word(k));
  endtask

  task automatic clear_mon();
    q.delete();
    done_cnt = 0;
  endtask

  int s;

  initial begin
    for (int i = 0; i < NR; i++) rf[i] = 32'(i * 3);
    for (int i = 0; i < ND; i++) dmem[i] = '0;
    dmem[0] = 32'd8;
    dmem[1] = 32'd1;

    // Reset state
    repeat (3) @(negedge clk);
    #1 chk_idle_outs("reset_outs");
    resetn = 1'b1;
    @(negedge clk); #1;

    // Full dump, ready always high: latency, ordering, length, Done pulse
    clear_mon();
    rdy_mode = 0;
    @(negedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    chk("lat1_valid", bus.out_valid, 0);
    chk("busy_up", busy, 1);
    chk("regaddr0", bus.reg_addr, 0);
    @(negedge clk); #1;
    chk("lat2_valid", bus.out_valid, 1);
    chk("first_word", cur_w(), exp_word(0));
    wait_done(400);
    chk("done_after_last", done_cyc - last_xfer, 1);
    chk("dump_len", last_xfer - s, NW + 2);
    chk("busy_in_done", busy, 0);
    check_seq(0, NW);
    chk("mem0_word", q[32], {32'd8, 2'b01, 8'd0, 1'b0});
    @(negedge clk); #1;
    chk("done_pulse", done, 0);
    chk("done_cnt_a", done_cnt, 1);

    // Back-pressure 1-0-0-1
    clear_mon();
    rdy_mode = 1;
    start_dump(s);
    wait_done(1500);
    check_seq(0, NW);
    chk("done_cnt_b", done_cnt, 1);

    // Start re-pulsed mid-dump is ignored
    clear_mon();
    rdy_mode = 0;
    start_dump(s);
    wait_words(10, 100);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(400);
    check_seq(0, NW);
    @(negedge clk); #1;
    chk("done_cnt_c", done_cnt, 1);
    chk("busy_c", busy, 0);

    // Reset at word 40 aborts, then a fresh dump from register 0
    clear_mon();
    rdy_mode = 1;
    start_dump(s);
    wait_words(40, 500);
    resetn = 1'b0;
    #1 chk_idle_outs("reset_mid");
    repeat (3) @(negedge clk);
    #1 chk("no_done_abort", done_cnt, 0);
    resetn = 1'b1;
    rdy_mode = 0;
    clear_mon();
    start_dump(s);
    wait_done(400);
    check_seq(0, NW);

    // Start in the Done cycle starts an identical second dump
    @(negedge clk); #1;
    clear_mon();
    start_dump(s);
    wait_done(400);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("restart_busy", busy, 1);
    wait_done(400);
    chk("done_cnt_e", done_cnt, 2);
    check_seq(NW, 2 * NW);

    // Checksum pattern (final word is the checksum when enabled)
    for (int i = 0; i < NR; i++) rf[i] = '0;
    for (int i = 0; i < ND; i++) dmem[i] = '0;
    rf[1]   = 32'hFFFF_0000;
    dmem[0] = 32'h0000_FFFF;
    @(negedge clk); #1;
    clear_mon();
    rdy_mode = 1;
    start_dump(s);
    wait_done(1500);
    check_seq(0, NW);
`ifdef DUMP_CHECKSUM_EN
    if (q.size() == NW) chk("csum_word", q[NW-1], {32'hFFFF_FFFF, 2'b10, 8'd0, 1'b1});
`else
    if (q.size() == NW) chk("last_mem_word", q[NW-1], {32'd0, 2'b01, 8'd63, 1'b1});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
